// File: rtl/clock_div_pkg.sv
// -----------------------------------------------------------------------------
// clock_div_pkg
//
// Shared constants and helpers for the programmable clock divider.
//
// The helpers work on a 32-bit word so that any divider width up to 32 bits can
// use them. Callers widen their operand on the way in and narrow the result on
// the way out.
//
// Contents:
//   DIV_MIN      smallest usable divisor; 0 and 1 are treated as this value.
//   div_word_t   working type for the helper functions.
//   eff_div      clamps a requested divisor to at least DIV_MIN.
//   high_cycles  number of high cycles in one period: Deff - floor(Deff/2).
// -----------------------------------------------------------------------------
package clock_div_pkg;

    localparam int DIV_MIN = 2;
    localparam int FN_W    = 32;

    typedef logic [FN_W-1:0] div_word_t;

    // A period of 0 or 1 cycles cannot hold both a high and a low phase, so
    // such requests are raised to the shortest period that can.
    function automatic div_word_t eff_div(input div_word_t d);
        return (d < div_word_t'(DIV_MIN)) ? div_word_t'(DIV_MIN) : d;
    endfunction

    // Odd divisors spend the extra cycle in the high phase.
    function automatic div_word_t high_cycles(input div_word_t deff);
        return deff - (deff >> 1);
    endfunction

endpackage

// File: rtl/clock_div_chan.sv
// -----------------------------------------------------------------------------
// clock_div_chan
//
// One divider channel. It holds the period counter, the active (effective)
// divisor, a single-entry pending-divisor slot, and the registered clock and
// strobe outputs.
//
// Optional build macro: CLOCK_DIV_PHASE_EN.
//   When it is defined, a sync loads the counter from the 'phase' input
//   instead of 0.
//
// Ports:
//   clk       system clock
//   reset_n   synchronous active-low reset
//   en        run enable; when low, the counter is held at 0
//   sync      restart the counter and apply any pending divisor
//   wr        accepted divisor write for this channel (already qualified)
//   wr_value  raw divisor value of the write
//   phase     counter load value on sync (CLOCK_DIV_PHASE_EN only)
//   pending   a written divisor is waiting to be applied
//   clk_out   divided clock (registered)
//   stb       one-cycle pulse coincident with each clk_out rising edge
// -----------------------------------------------------------------------------
module clock_div_chan
    import clock_div_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 sync,
    input  logic                 wr,
    input  logic [DIV_WIDTH-1:0] wr_value,
`ifdef CLOCK_DIV_PHASE_EN
    input  logic [DIV_WIDTH-1:0] phase,
`endif
    output logic                 pending,
    output logic                 clk_out,
    output logic                 stb
);

    // Clamp a raw divisor of this channel's width to its effective value.
    function automatic logic [DIV_WIDTH-1:0] to_eff(input logic [DIV_WIDTH-1:0] d);
        return DIV_WIDTH'(eff_div(div_word_t'(d)));
    endfunction

    localparam logic [DIV_WIDTH-1:0] RESET_DIV = DIV_WIDTH'(eff_div(div_word_t'(DEFAULT_DIV)));

    // div_reg always holds the effective divisor, so it is never below DIV_MIN.
    logic [DIV_WIDTH-1:0] cnt_reg,      cnt_next;
    logic [DIV_WIDTH-1:0] div_reg,      div_next;
    logic [DIV_WIDTH-1:0] pend_val_reg, pend_val_next;
    logic                 pend_reg,     pend_next;
    logic                 clk_reg,      clk_next;
    logic                 stb_reg,      stb_next;

    logic [DIV_WIDTH-1:0] high_cnt;
    logic [DIV_WIDTH-1:0] last_cnt;
    logic [DIV_WIDTH-1:0] sync_load;
    logic                 boundary;
    logic                 apply;

    always_comb begin
        high_cnt = DIV_WIDTH'(high_cycles(div_word_t'(div_reg)));
        last_cnt = div_reg - DIV_WIDTH'(1);
        boundary = en & (cnt_reg == last_cnt);

        // apply looks only at the registered pending flag. A write accepted in
        // this same cycle therefore waits for the next boundary, disable or sync.
        apply    = pend_reg & (boundary | ~en | sync);
        div_next = apply ? to_eff(pend_val_reg) : div_reg;

`ifdef CLOCK_DIV_PHASE_EN
        // The phase offset is checked against the divisor that will be in force
        // after this sync. An out-of-range offset falls back to 0.
        sync_load = (phase < div_next) ? phase : '0;
`else
        sync_load = '0;
`endif

        // A disabled channel sits at count 0, even during a sync. The first
        // enabled cycle then starts a fresh period.
        if (!en) begin
            cnt_next = '0;
        end else if (sync) begin
            cnt_next = sync_load;
        end else if (boundary) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + DIV_WIDTH'(1);
        end

        // Ready is ~pend_reg, so wr and apply never occur together. Giving the
        // write priority keeps the slot coherent anyway.
        pend_next     = pend_reg;
        pend_val_next = pend_val_reg;
        if (wr) begin
            pend_next     = 1'b1;
            pend_val_next = wr_value;
        end else if (apply) begin
            pend_next     = 1'b0;
        end

        // The outputs trail the counter by one cycle and use the divisor that
        // is active for the current count.
        clk_next = en & (cnt_reg < high_cnt);
        stb_next = en & (cnt_reg == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_reg      <= '0;
            div_reg      <= RESET_DIV;
            pend_val_reg <= '0;
            pend_reg     <= 1'b0;
            clk_reg      <= 1'b0;
            stb_reg      <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            div_reg      <= div_next;
            pend_val_reg <= pend_val_next;
            pend_reg     <= pend_next;
            clk_reg      <= clk_next;
            stb_reg      <= stb_next;
        end
    end

    assign pending = pend_reg;
    assign clk_out = clk_reg;
    assign stb     = stb_reg;

endmodule

// File: rtl/clock_div_prog.sv
// -----------------------------------------------------------------------------
// clock_div_prog
//
// Multi-channel, runtime-programmable clock divider. Each channel produces a
// registered divided clock and a one-cycle period strobe. Divisors are written
// through a valid/ready port and take effect only at a period boundary, on
// disable, or on sync, so no runt pulses are produced.
//
// Optional build macro: CLOCK_DIV_PHASE_EN.
//   When it is defined, the i_phase port is added. It holds per-channel counter
//   load values that are applied on i_sync.
//
// Ports:
//   i_clk        system clock
//   i_reset_n    synchronous active-low reset
//   i_en         per-channel run enable
//   i_sync       restart all channel counters, apply pending divisors
//   i_div_valid  divisor write request
//   i_div_chan   target channel of the write
//   i_div_value  new divisor (0 and 1 behave as 2)
//   i_phase      per-channel sync load value, slice c*DIV_WIDTH +: DIV_WIDTH
//                (CLOCK_DIV_PHASE_EN only)
//   o_div_ready  write can be accepted (target channel has no pending divisor)
//   o_clk        divided clocks (registered)
//   o_stb        one-cycle strobes coincident with o_clk rising edges
// -----------------------------------------------------------------------------
module clock_div_prog
    import clock_div_pkg::*;
#(
    parameter  int CHANNELS    = 4,
    parameter  int DIV_WIDTH   = 16,
    parameter  int DEFAULT_DIV = 6,
    localparam int CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [CHANNELS-1:0]           i_en,
    input  logic                          i_sync,
    input  logic                          i_div_valid,
    input  logic [CHAN_W-1:0]             i_div_chan,
    input  logic [DIV_WIDTH-1:0]          i_div_value,
`ifdef CLOCK_DIV_PHASE_EN
    input  logic [CHANNELS*DIV_WIDTH-1:0] i_phase,
`endif
    output logic                          o_div_ready,
    output logic [CHANNELS-1:0]           o_clk,
    output logic [CHANNELS-1:0]           o_stb
);

    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] wr_sel;

    // Ready mux. A channel number that does not exist reads as ready, and
    // no channel decodes it, so such a write is accepted and discarded instead
    // of stalling the port forever.
    always_comb begin
        o_div_ready = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (i_div_chan == CHAN_W'(c)) begin
                o_div_ready = ~pending[c];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign wr_sel[gi] = i_div_valid & o_div_ready & (i_div_chan == CHAN_W'(gi));

            clock_div_chan #(
                .DIV_WIDTH   (DIV_WIDTH),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_chan (
                .clk      (i_clk),
                .reset_n  (i_reset_n),
                .en       (i_en[gi]),
                .sync     (i_sync),
                .wr       (wr_sel[gi]),
                .wr_value (i_div_value),
`ifdef CLOCK_DIV_PHASE_EN
                .phase    (i_phase[gi*DIV_WIDTH +: DIV_WIDTH]),
`endif
                .pending  (pending[gi]),
                .clk_out  (o_clk[gi]),
                .stb      (o_stb[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clock_div_prog.sv
module tb_clock_div_prog;

    localparam int CH  = 4;
    localparam int W   = 16;
    localparam int DEF = 6;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [CH-1:0] en;
    logic          sync;
    logic          div_valid;
    logic [CW-1:0] div_chan;
    logic [W-1:0]  div_value;
`ifdef CLOCK_DIV_PHASE_EN
    logic [CH*W-1:0] phase;
`endif
    logic          div_ready;
    logic [CH-1:0] dclk;
    logic [CH-1:0] dstb;

    always #5 clk = ~clk;

    clock_div_prog #(.CHANNELS(CH), .DIV_WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_en        (en),
        .i_sync      (sync),
        .i_div_valid (div_valid),
        .i_div_chan  (div_chan),
        .i_div_value (div_value),
`ifdef CLOCK_DIV_PHASE_EN
        .i_phase     (phase),
`endif
        .o_div_ready (div_ready),
        .o_clk       (dclk),
        .o_stb       (dstb)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per channel, the position within the current period,
    // the period length, and the single pending-divisor slot.
    int          m_pos [CH];
    int          m_per [CH];
    int          m_pv  [CH];
    bit          m_pend[CH];
    bit [CH-1:0] m_clk;
    bit [CH-1:0] m_stb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sync_pos(input int c, input int per);
`ifdef CLOCK_DIV_PHASE_EN
        int ph;
        ph = int'(phase[c*W +: W]);
        return (ph < per) ? ph : 0;
`else
        return 0;
`endif
    endfunction

    // Advance the model by one rising edge, using the inputs now being driven.
    task automatic model_edge();
        int  acc;
        bit  e, wrap, app;
        if (!reset_n) begin
            for (int c = 0; c < CH; c++) begin
                m_pos[c] = 0; m_per[c] = DEF; m_pv[c] = 0; m_pend[c] = 0;
            end
            m_clk = '0;
            m_stb = '0;
            return;
        end
        acc = (div_valid && !m_pend[div_chan]) ? int'(div_chan) : -1;
        for (int c = 0; c < CH; c++) begin
            e = en[c];
            // High for the first half of the period; the odd extra cycle is high.
            m_clk[c] = e && (2 * m_pos[c] < m_per[c]);
            m_stb[c] = e && (m_pos[c] == 0);
            wrap = e && (m_pos[c] == m_per[c] - 1);
            app  = m_pend[c] && (wrap || !e || sync);
            if (app) begin
                m_per[c]  = (m_pv[c] < 2) ? 2 : m_pv[c];
                m_pend[c] = 0;
            end
            if (!e)        m_pos[c] = 0;
            else if (sync) m_pos[c] = sync_pos(c, m_per[c]);
            else if (wrap) m_pos[c] = 0;
            else           m_pos[c] = m_pos[c] + 1;
            if (acc == c) begin
                m_pend[c] = 1;
                m_pv[c]   = int'(div_value);
            end
        end
    endtask

    // One clock cycle: check ready before the edge, step the model at the edge,
    // then check the registered outputs 1 time unit later.
    task automatic tick();
        #1;
        chk("ready", div_ready, !m_pend[div_chan]);
        @(posedge clk);
        model_edge();
        #1;
        chk("o_clk", dclk, m_clk);
        chk("o_stb", dstb, m_stb);
    endtask

    // Measure the number of cycles between two consecutive strobes on channel
    // ch. The result is -1 if either strobe is missing within the bound.
    task automatic measure_gap(input int ch, output int gap);
        int n;
        gap = -1;
        n = 0;
        while (!dstb[ch] && n < 40) begin tick(); n++; end
        if (dstb[ch]) begin
            n = 0;
            do begin tick(); n++; end while (!dstb[ch] && n < 40);
            if (dstb[ch]) gap = n;
        end
    endtask

    task automatic write_div(input int ch, input int val);
        int n;
        div_valid = 1'b1;
        div_chan  = CW'(ch);
        div_value = W'(val);
        #1;
        n = 0;
        while (!div_ready && n < 40) begin tick(); n++; end
        chk("write_wait_bound", (n < 40), 1);
        tick();
        div_valid = 1'b0;
    endtask

    initial begin
        int gap;
        int n;
        reset_n   = 1'b0;
        en        = '0;
        sync      = 1'b0;
        div_valid = 1'b0;
        div_chan  = '0;
        div_value = '0;
`ifdef CLOCK_DIV_PHASE_EN
        phase     = '0;
`endif
        for (int c = 0; c < CH; c++) begin
            m_pos[c] = 0; m_per[c] = DEF; m_pv[c] = 0; m_pend[c] = 0;
        end
        m_clk = '0;
        m_stb = '0;

        // Reset state.
        tick(); tick();
        chk("reset_clk", dclk, 0);
        chk("reset_stb", dstb, 0);
        chk("reset_ready", div_ready, 1);

        // Default divisor 6 on channel 0: strobes at cycles 1, 7 and 13; high 3, low 3.
        reset_n = 1'b1;
        en      = 4'b0001;
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk("def_stb0", dstb[0], (k % 6) == 1);
            chk("def_clk0", dclk[0], ((k - 1) % 6) < 3);
            chk("def_others", dclk[3:1] | dstb[3:1], 0);
        end

        // Mid-period write D=5: the old period completes, then the period is 5.
        write_div(0, 5);
        repeat (8) tick();
        measure_gap(0, gap);
        chk("gap_d5", gap, 5);

        // D=0 and D=1 both give a period of 2.
        write_div(0, 0);
        repeat (8) tick();
        measure_gap(0, gap);
        chk("gap_d0", gap, 2);
        write_div(0, 1);
        repeat (8) tick();
        measure_gap(0, gap);
        chk("gap_d1", gap, 2);

        // Back-to-back writes to ch1 stall; a write to ch2 is accepted meanwhile.
        en        = 4'b0011;
        div_valid = 1'b1;
        div_chan  = 2'd1;
        div_value = 16'd3;
        tick();
        div_value = 16'd7;
        #1;
        chk("ch1_stall", div_ready, 0);
        div_chan  = 2'd2;
        div_value = 16'd9;
        #1;
        chk("ch2_ready", div_ready, 1);
        tick();
        div_chan  = 2'd1;
        div_value = 16'd7;
        #1;
        n = 0;
        while (!div_ready && n < 40) begin tick(); n++; end
        chk("ch1_stalled_some", (n > 0), 1);
        chk("ch1_wait_bound", (n < 40), 1);
        tick();
        div_valid = 1'b0;
        repeat (10) tick();

        // ch0 D=4, ch1 D=8, then a sync: both channels strobe together.
        write_div(0, 4);
        write_div(1, 8);
        repeat (20) tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tick();
        chk("sync_stb", dstb[1:0], 2'b11);
        repeat (16) tick();

        // Reset mid-period discards a pending write and restores divisor 6.
        div_valid = 1'b1;
        div_chan  = 2'd0;
        div_value = 16'd9;
        tick();
        div_valid = 1'b0;
        reset_n   = 1'b0;
        tick();
        chk("rst_mid_clk", dclk, 0);
        chk("rst_mid_stb", dstb, 0);
        chk("rst_mid_ready", div_ready, 1);
        reset_n = 1'b1;
        en      = 4'b0001;
        measure_gap(0, gap);
        chk("gap_after_reset", gap, 6);

`ifdef CLOCK_DIV_PHASE_EN
        // Phase 2 with D=4: the strobe appears on the 3rd cycle after the sync.
        write_div(0, 4);
        phase[0 +: W] = 16'd2;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!dstb[0] && n < 10);
        chk("phase_delay", n, 3);
        phase = '0;
`endif

        // Randomized traffic checked against the model every cycle.
        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(199) != 0);
            for (int c = 0; c < CH; c++) en[c] = ($urandom_range(7) != 0);
            sync      = ($urandom_range(15) == 0);
            div_valid = ($urandom_range(2) == 0);
            div_chan  = CW'($urandom_range(CH - 1));
            div_value = W'($urandom_range(9));
`ifdef CLOCK_DIV_PHASE_EN
            for (int c = 0; c < CH; c++) phase[c*W +: W] = W'($urandom_range(9));
`endif
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
